npc_bp: RTL and testbench

- Fetch-side program counter with branch prediction; next-generation successor of the combinational next-PC unit.
- Holds the fetch PC register and predicts the next fetch address from a parametrised branch target buffer (BTB) with 2-bit saturating counters.
- Resolves control transfers from the execute stage using the existing ctrl_NPC encoding.
- On a misprediction, redirects fetch, raises flush and updates the BTB.
- Sits between instruction memory (fetch) and the execute stage of the pipelined core.

---
 rtl/npc_pkg.sv | 26 ++
 rtl/npc_btb.sv | 76 +++++++
 rtl/npc_bp.sv | 94 +++++++++
 tb/tb_npc_bp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types for the fetch next-PC predictor: control-transfer encoding and
// 2-bit saturating counter helpers.
package npc_pkg;

  typedef enum logic [2:0] {
    CTRL_SEQ  = 3'b000,
    CTRL_RSV  = 3'b001,
    CTRL_JAL  = 3'b010,
    CTRL_JALR = 3'b011,
    CTRL_BEQ  = 3'b100,
    CTRL_BNE  = 3'b101,
    CTRL_BLT  = 3'b110,
    CTRL_BGE  = 3'b111
  } ctrl_npc_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// registered update port. Word-aligned PCs only, so bits [1:0] never enter.
module npc_btb
  import npc_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:2] lk_pc,
  output logic                 lk_taken,
  output logic [DATAWIDTH-1:0] lk_target,
  input  logic                 up_en,
  input  logic [DATAWIDTH-1:2] up_pc,
  input  logic                 up_taken,
  input  logic [DATAWIDTH-1:0] up_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATAWIDTH - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0]                vld_q, vld_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [BTB_ENTRIES-1:0][1:0]           ctr_q, ctr_d;
  logic [BTB_ENTRIES-1:0][DATAWIDTH-1:0] tgt_q, tgt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[DATAWIDTH-1:IDX_W+2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[DATAWIDTH-1:IDX_W+2];

  // Lookup reads the registered arrays, so a same-cycle update is not seen.
  assign lk_hit    = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
  assign lk_target = tgt_q[lk_idx];
  assign up_hit    = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    ctr_d = ctr_q;
    tgt_d = tgt_q;
    if (up_en) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_next(ctr_q[up_idx], up_taken);
        if (up_taken) tgt_d[up_idx] = up_target;
      end else if (up_taken) begin
        // Conflicting entry is simply replaced; not-taken misses leave it alone.
        vld_d[up_idx] = 1'b1;
        tag_d[up_idx] = up_tag;
        ctr_d[up_idx] = CTR_WT;
        tgt_d[up_idx] = up_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
      ctr_q <= {BTB_ENTRIES{CTR_WNT}};
      tgt_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      ctr_q <= ctr_d;
      tgt_q <= tgt_d;
    end
  end

endmodule

// File: rtl/npc_bp.sv
// Fetch PC register with BTB prediction, execute-stage resolution, flush on
// mispredict and a saturating mispredict counter.
module npc_bp
  import npc_pkg::*;
#(
  parameter int                  DATAWIDTH   = 32,
  parameter int                  BTB_ENTRIES = 16,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  output logic [DATAWIDTH-1:0] pc,
  output logic [DATAWIDTH-1:0] pred_npc,
  output logic                 pred_taken,
  input  logic                 ex_valid,
  input  logic [DATAWIDTH-1:0] ex_pc,
  input  logic [DATAWIDTH-1:0] ex_pred_npc,
  input  logic [2:0]           ex_ctrl_NPC,
  input  logic [1:0]           ex_flags,
  input  logic [DATAWIDTH-1:0] ex_imm,
  input  logic [DATAWIDTH-1:0] ex_result_ALU,
  output logic [DATAWIDTH-1:0] ex_pc_add4,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] btb_target, act_npc;
  logic                 btb_taken, act_taken, is_cti;
  ctrl_npc_e            ctrl;

  npc_btb #(
    .DATAWIDTH  (DATAWIDTH),
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .lk_pc    (pc_q[DATAWIDTH-1:2]),
    .lk_taken (btb_taken),
    .lk_target(btb_target),
    .up_en    (ex_valid && is_cti),
    .up_pc    (ex_pc[DATAWIDTH-1:2]),
    .up_taken (act_taken),
    .up_target(act_npc)
  );

  assign pc             = pc_q;
  assign pred_taken     = btb_taken;
  assign pred_npc       = btb_taken ? btb_target : pc_q + DATAWIDTH'(4);
  assign ex_pc_add4     = ex_pc + DATAWIDTH'(4);
  assign mispredict_cnt = cnt_q;
  assign ctrl           = ctrl_npc_e'(ex_ctrl_NPC);

  always_comb begin
    is_cti    = 1'b0;
    act_taken = 1'b0;
    case (ctrl)
      CTRL_JAL, CTRL_JALR: begin is_cti = 1'b1; act_taken = 1'b1;          end
      CTRL_BEQ:            begin is_cti = 1'b1; act_taken =  ex_flags[0];  end
      CTRL_BNE:            begin is_cti = 1'b1; act_taken = !ex_flags[0];  end
      CTRL_BLT:            begin is_cti = 1'b1; act_taken =  ex_flags[1];  end
      CTRL_BGE:            begin is_cti = 1'b1; act_taken = !ex_flags[1];  end
      default:             ;
    endcase

    if (ctrl == CTRL_JALR) act_npc = ex_result_ALU & ~DATAWIDTH'(1);
    else if (act_taken)    act_npc = ex_pc + ex_imm;
    else                   act_npc = ex_pc_add4;

    flush = ex_valid && (act_npc != ex_pred_npc);

    // A redirect must win over stall or the squashed path would keep fetching.
    if (flush)      pc_d = act_npc;
    else if (stall) pc_d = pc_q;
    else            pc_d = pred_npc;

    cnt_d = cnt_q;
    if (flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_bp.sv
// Scenario bench for npc_bp: expected fetch PCs are queued when stimulus is
// driven and popped when the edge that produces them has passed.
module tb_npc_bp;

  localparam int          DW  = 32;
  localparam int          NE  = 16;
  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] pc, pred_npc, ex_pc_add4;
  logic          pred_taken, flush;
  logic          ex_valid = 1'b0;
  logic [DW-1:0] ex_pc = '0, ex_pred_npc = '0, ex_imm = '0, ex_result_ALU = '0;
  logic [2:0]    ex_ctrl_NPC = 3'b000;
  logic [1:0]    ex_flags = 2'b00;
  logic [CW-1:0] mispredict_cnt;

  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  logic [CW-1:0] exp_cnt = '0;

  npc_bp #(.DATAWIDTH(DW), .BTB_ENTRIES(NE), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .pred_npc(pred_npc),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_pred_npc(ex_pred_npc), .ex_ctrl_NPC(ex_ctrl_NPC), .ex_flags(ex_flags),
    .ex_imm(ex_imm), .ex_result_ALU(ex_result_ALU), .ex_pc_add4(ex_pc_add4),
    .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_ctrl_NPC = 3'b000; ex_flags = 2'b00;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Steers fetch to addr with a sequential mispredict; leaves the BTB untouched.
  task automatic redirect(input logic [DW-1:0] addr);
    ex_valid = 1'b1; ex_ctrl_NPC = 3'b000; ex_pc = addr - 32'd4; ex_pred_npc = ~addr;
    tick(); bump_cnt(); idle_ex();
  endtask

  task automatic drive_ex(input logic [2:0] c, input logic [DW-1:0] p, input logic [DW-1:0] imm,
                          input logic [1:0] f, input logic [DW-1:0] pn);
    ex_valid = 1'b1; ex_ctrl_NPC = c; ex_pc = p; ex_imm = imm; ex_flags = f; ex_pred_npc = pn;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (pc !== RPC) $display("FAIL reset_pc got %h exp %h", pc, RPC); else n_pass++;
    n_total++; if (mispredict_cnt !== '0) $display("FAIL reset_cnt got %h exp 0", mispredict_cnt); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %b exp 0", pred_taken); else n_pass++;
    n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush); else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 3; i++) exp_q.push_back(RPC + 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_total++; if (pc !== e) $display("FAIL free_run_pc got %h exp %h", pc, e); else n_pass++;
      n_total++; if (pred_taken !== 1'b0) $display("FAIL free_run_taken got %b exp 0", pred_taken); else n_pass++;
      if (i < 2) tick();
    end
  endtask

  task automatic test_cold_jal();
    tick();
    drive_ex(3'b010, 32'h10, 32'h40, 2'b00, 32'h14); #1;
    n_total++; if (flush !== 1'b1) $display("FAIL jal_flush got %b exp 1", flush); else n_pass++;
    exp_q.push_back(32'h50);
    tick(); bump_cnt(); idle_ex(); #1;
    e = exp_q.pop_front();
    n_total++; if (pc !== e) $display("FAIL jal_redirect got %h exp %h", pc, e); else n_pass++;
    n_total++; if (mispredict_cnt !== exp_cnt) $display("FAIL jal_cnt got %h exp %h", mispredict_cnt, exp_cnt); else n_pass++;
    redirect(32'h10); #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL jal_pred_taken got %b exp 1", pred_taken); else n_pass++;
    n_total++; if (pred_npc !== 32'h50) $display("FAIL jal_pred_npc got %h exp 50", pred_npc); else n_pass++;
  endtask

  task automatic test_loop_branch();
    drive_ex(3'b101, 32'h20, 32'hFFFF_FFF8, 2'b00, 32'h24); #1;
    n_total++; if (flush !== 1'b1) $display("FAIL bne_alloc_flush got %b exp 1", flush); else n_pass++;
    tick(); bump_cnt();
    for (int i = 0; i < 2; i++) begin
      drive_ex(3'b101, 32'h20, 32'hFFFF_FFF8, 2'b00, 32'h18); #1;
      n_total++; if (flush !== 1'b0) $display("FAIL bne_taken_flush got %b exp 0", flush); else n_pass++;
      tick();
    end
    idle_ex();
    redirect(32'h20); #1;
    n_total++; if (pred_npc !== 32'h18) $display("FAIL bne_trained_npc got %h exp 18", pred_npc); else n_pass++;
    drive_ex(3'b101, 32'h20, 32'hFFFF_FFF8, 2'b01, 32'h18); #1;
    n_total++; if (flush !== 1'b1) $display("FAIL bne_exit_flush got %b exp 1", flush); else n_pass++;
    exp_q.push_back(32'h24);
    tick(); bump_cnt(); idle_ex();
    e = exp_q.pop_front();
    n_total++; if (pc !== e) $display("FAIL bne_exit_pc got %h exp %h", pc, e); else n_pass++;
    // Counter now 10: still taken; one more not-taken must drop it to 01.
    redirect(32'h20); #1;
    n_total++; if (pred_taken !== 1'b1) $display("FAIL bne_weak_taken got %b exp 1", pred_taken); else n_pass++;
    drive_ex(3'b101, 32'h20, 32'hFFFF_FFF8, 2'b01, 32'h18);
    tick(); bump_cnt(); idle_ex();
    redirect(32'h20); #1;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL bne_untrained got %b exp 0", pred_taken); else n_pass++;
    n_total++; if (pred_npc !== 32'h24) $display("FAIL bne_untrained_npc got %h exp 24", pred_npc); else n_pass++;
  endtask

  task automatic test_jalr();
    drive_ex(3'b011, 32'h100, 32'h0, 2'b00, 32'h0); ex_result_ALU = 32'h1235; #1;
    n_total++; if (flush !== 1'b1) $display("FAIL jalr_flush got %b exp 1", flush); else n_pass++;
    n_total++; if (ex_pc_add4 !== 32'h104) $display("FAIL jalr_link got %h exp 104", ex_pc_add4); else n_pass++;
    exp_q.push_back(32'h1234);
    tick(); bump_cnt(); idle_ex();
    e = exp_q.pop_front();
    n_total++; if (pc !== e) $display("FAIL jalr_target got %h exp %h", pc, e); else n_pass++;
  endtask

  task automatic test_stall_flush();
    logic [DW-1:0] held;
    stall = 1'b1; #1;
    held = pc;
    for (int i = 0; i < 3; i++) exp_q.push_back(held);
    for (int i = 0; i < 3; i++) begin
      tick(); e = exp_q.pop_front();
      n_total++; if (pc !== e) $display("FAIL stall_hold got %h exp %h", pc, e); else n_pass++;
    end
    drive_ex(3'b010, 32'h200, 32'h20, 2'b00, 32'h0); ex_valid = 1'b0; #1;
    n_total++; if (flush !== 1'b0) $display("FAIL invalid_no_flush got %b exp 0", flush); else n_pass++;
    ex_pred_npc = 32'h204; ex_valid = 1'b1; #1;
    n_total++; if (flush !== 1'b1) $display("FAIL stall_flush got %b exp 1", flush); else n_pass++;
    exp_q.push_back(32'h220);
    tick(); bump_cnt(); idle_ex(); stall = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (pc !== e) $display("FAIL stall_flush_pc got %h exp %h", pc, e); else n_pass++;
    n_total++; if (mispredict_cnt !== exp_cnt) $display("FAIL stall_cnt got %h exp %h", mispredict_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_cnt_saturate();
    for (int i = 0; i < 12; i++) redirect(32'h300 + 32'(8 * i));
    #1;
    n_total++; if (mispredict_cnt !== exp_cnt) $display("FAIL cnt_saturate got %h exp %h", mispredict_cnt, exp_cnt); else n_pass++;
    n_total++; if (mispredict_cnt !== {CW{1'b1}}) $display("FAIL cnt_all_ones got %h exp %h", mispredict_cnt, {CW{1'b1}}); else n_pass++;
  endtask

  task automatic test_async_reset();
    redirect(32'h10);
    #3 rst_n = 1'b0; #1;
    n_total++; if (pc !== RPC) $display("FAIL areset_pc got %h exp %h", pc, RPC); else n_pass++;
    n_total++; if (mispredict_cnt !== '0) $display("FAIL areset_cnt got %h exp 0", mispredict_cnt); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_total++; if (pc !== 32'h10) $display("FAIL areset_walk got %h exp 10", pc); else n_pass++;
    n_total++; if (pred_taken !== 1'b0) $display("FAIL areset_btb_cleared got %b exp 0", pred_taken); else n_pass++;
    n_total++; if (pred_npc !== 32'h14) $display("FAIL areset_pred_npc got %h exp 14", pred_npc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cold_jal();
    test_loop_branch();
    test_jalr();
    test_stall_flush();
    test_cnt_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
